// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the two-queue round-robin merge arbiter.
package rr_mux_arbiter_pkg;

  localparam int unsigned DataSizeDefault = 4;
  localparam int unsigned BurstCntW       = 4;

  typedef logic [BurstCntW-1:0] burst_cnt_t;

  // Records which queue was popped in the previous cycle.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServe0 = 2'd1,
    StServe1 = 2'd2
  } state_e;

  function automatic burst_cnt_t sat_inc(burst_cnt_t cnt, burst_cnt_t max);
    return (cnt < max) ? cnt + burst_cnt_t'(1) : cnt;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Upstream queue heads/flags, pop strobes and the downstream push port of the merge arbiter.
interface rr_mux_arbiter_if #(
  parameter int unsigned DATA_SIZE = rr_mux_arbiter_pkg::DataSizeDefault
);

  logic                 empty0;
  logic                 empty1;
  logic [DATA_SIZE-1:0] data_in0;
  logic [DATA_SIZE-1:0] data_in1;
  logic                 almost_full_out;
  logic                 pop0;
  logic                 pop1;
  logic                 push_out;
  logic [DATA_SIZE-1:0] data_out;

  modport slave (
    input  empty0, empty1, data_in0, data_in1, almost_full_out,
    output pop0, pop1, push_out, data_out
  );

  modport master (
    output empty0, empty1, data_in0, data_in1, almost_full_out,
    input  pop0, pop1, push_out, data_out
  );

endinterface

// File: rtl/rr_mux_arbiter_grant.sv
// Combinational round-robin grant with bounded burst; at most one grant per cycle.
module rr_mux_arbiter_grant
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned BURST = 2
) (
  input  state_e     state_i,
  input  burst_cnt_t burst_cnt_i,
  input  logic       last_i,
  input  logic       empty0_i,
  input  logic       empty1_i,
  input  logic       almost_full_i,
  output logic       grant0_o,
  output logic       grant1_o
);

  localparam burst_cnt_t BurstMax = burst_cnt_t'(BURST);

  logic burst_done;

  always_comb begin
    grant0_o   = 1'b0;
    grant1_o   = 1'b0;
    burst_done = (burst_cnt_i >= BurstMax);
    if (!almost_full_i && !(empty0_i && empty1_i)) begin
      if (empty1_i) begin
        grant0_o = 1'b1;
      end else if (empty0_i) begin
        grant1_o = 1'b1;
      end else begin
        unique case (state_i)
          StServe0: begin
            grant0_o = !burst_done;
            grant1_o = burst_done;
          end
          StServe1: begin
            grant1_o = !burst_done;
            grant0_o = burst_done;
          end
          // From idle the queue not served most recently goes first.
          default: begin
            grant0_o = last_i;
            grant1_o = !last_i;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Merges two show-ahead queues into one downstream FIFO, one registered word per cycle.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DataSizeDefault,
  parameter int unsigned BURST     = 2
) (
  input logic               clk,
  input logic               reset_L,
  rr_mux_arbiter_if.slave   bus
);

  localparam burst_cnt_t BurstMax = burst_cnt_t'(BURST);

  state_e               state_q, state_d;
  burst_cnt_t           cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 push_q, push_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 grant0, grant1;

  rr_mux_arbiter_grant #(
    .BURST(BURST)
  ) u_grant (
    .state_i      (state_q),
    .burst_cnt_i  (cnt_q),
    .last_i       (last_q),
    .empty0_i     (bus.empty0),
    .empty1_i     (bus.empty1),
    .almost_full_i(bus.almost_full_out),
    .grant0_o     (grant0),
    .grant1_o     (grant1)
  );

  // Pops are held off while reset is asserted so no word is lost upstream.
  assign bus.pop0     = grant0 & reset_L;
  assign bus.pop1     = grant1 & reset_L;
  assign bus.push_out = push_q;
  assign bus.data_out = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    push_d  = grant0 | grant1;
    if (grant0) begin
      data_d = bus.data_in0;
      if (state_q == StServe0) begin
        cnt_d = sat_inc(cnt_q, BurstMax);
      end else begin
        state_d = StServe0;
        cnt_d   = burst_cnt_t'(1);
        last_d  = 1'b0;
      end
    end else if (grant1) begin
      data_d = bus.data_in1;
      if (state_q == StServe1) begin
        cnt_d = sat_inc(cnt_q, BurstMax);
      end else begin
        state_d = StServe1;
        cnt_d   = burst_cnt_t'(1);
        last_d  = 1'b1;
      end
    end else if (bus.empty0 && bus.empty1) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      push_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      push_q  <= push_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Drives a BURST=2 and a BURST=1 arbiter with identical queue traffic against a queue-level model.
module tb_rr_mux_arbiter;

  localparam int unsigned DW = 4;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.DATA_SIZE(DW)) bus_b2 ();
  rr_mux_arbiter_if #(.DATA_SIZE(DW)) bus_b1 ();

  rr_mux_arbiter #(.DATA_SIZE(DW), .BURST(2)) dut_b2 (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus_b2.slave)
  );

  rr_mux_arbiter #(.DATA_SIZE(DW), .BURST(1)) dut_b1 (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus_b1.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int burst_of [2] = '{2, 1};

  // Upstream queue contents and captured downstream words, per DUT (0: BURST=2, 1: BURST=1).
  logic [DW-1:0] q0  [2][$];
  logic [DW-1:0] q1  [2][$];
  logic [DW-1:0] got [2][$];
  logic          af;

  // Arbitration history: queue currently in a run (-1 none), run length, idle preference.
  int owner [2];
  int run   [2];
  int pref  [2];

  logic          exp_pop0 [2], exp_pop1 [2], exp_push [2];
  logic [DW-1:0] exp_data [2];
  logic          obs_pop0 [2], obs_pop1 [2], obs_push [2], obs_e1 [2];
  logic [DW-1:0] obs_data [2];

  function automatic logic [DW-1:0] head(int d, int qi);
    if (qi == 0) return (q0[d].size() != 0) ? q0[d][0] : '0;
    return (q1[d].size() != 0) ? q1[d][0] : '0;
  endfunction

  function automatic int model_grant(int d);
    bit ne0;
    bit ne1;
    ne0 = (q0[d].size() != 0);
    ne1 = (q1[d].size() != 0);
    if (af || (!ne0 && !ne1)) return -1;
    if (ne0 != ne1) return ne0 ? 0 : 1;
    if (owner[d] < 0) return pref[d];
    return (run[d] < burst_of[d]) ? owner[d] : 1 - owner[d];
  endfunction

  task automatic model_update(int d, int g);
    if (g >= 0) begin
      if (g == owner[d]) begin
        run[d] = (run[d] + 1 > burst_of[d]) ? burst_of[d] : run[d] + 1;
      end else begin
        owner[d] = g;
        run[d]   = 1;
        pref[d]  = 1 - g;
      end
    end else if (q0[d].size() == 0 && q1[d].size() == 0) begin
      owner[d] = -1;
      run[d]   = 0;
    end
  endtask

  task automatic drive_inputs();
    bus_b2.empty0          = (q0[0].size() == 0);
    bus_b2.empty1          = (q1[0].size() == 0);
    bus_b2.data_in0        = head(0, 0);
    bus_b2.data_in1        = head(0, 1);
    bus_b2.almost_full_out = af;
    bus_b1.empty0          = (q0[1].size() == 0);
    bus_b1.empty1          = (q1[1].size() == 0);
    bus_b1.data_in0        = head(1, 0);
    bus_b1.data_in1        = head(1, 1);
    bus_b1.almost_full_out = af;
  endtask

  // One clock cycle: drive queue heads, sample pops, advance model, capture the push.
  task automatic step();
    int g;
    @(negedge clk);
    drive_inputs();
    #1;
    obs_pop0[0] = bus_b2.pop0;
    obs_pop1[0] = bus_b2.pop1;
    obs_pop0[1] = bus_b1.pop0;
    obs_pop1[1] = bus_b1.pop1;
    obs_e1[0]   = bus_b2.empty1;
    obs_e1[1]   = bus_b1.empty1;
    for (int d = 0; d < 2; d++) begin
      g = model_grant(d);
      exp_pop0[d] = (g == 0);
      exp_pop1[d] = (g == 1);
      exp_push[d] = (g >= 0);
      if (g >= 0) exp_data[d] = head(d, g);
      model_update(d, g);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (obs_pop0[d] && q0[d].size() != 0) void'(q0[d].pop_front());
      if (obs_pop1[d] && q1[d].size() != 0) void'(q1[d].pop_front());
    end
    #1;
    obs_push[0] = bus_b2.push_out;
    obs_data[0] = bus_b2.data_out;
    obs_push[1] = bus_b1.push_out;
    obs_data[1] = bus_b1.data_out;
    for (int d = 0; d < 2; d++) if (obs_push[d]) got[d].push_back(obs_data[d]);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    af      = 1'b0;
    for (int d = 0; d < 2; d++) begin
      q0[d].delete();
      q1[d].delete();
      got[d].delete();
      owner[d]    = -1;
      run[d]      = 0;
      pref[d]     = 0;
      exp_data[d] = '0;
      exp_push[d] = 1'b0;
    end
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic load(input logic [DW-1:0] w0 [$], input logic [DW-1:0] w1 [$]);
    for (int d = 0; d < 2; d++) begin
      foreach (w0[k]) q0[d].push_back(w0[k]);
      foreach (w1[k]) q1[d].push_back(w1[k]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    // Queue heads valid while reset is low: pops must stay off.
    reset_L = 1'b0;
    bus_b2.empty0 = 1'b0;
    bus_b1.empty1 = 1'b0;
    #1;
    n_tests++;
    if ({bus_b2.pop0, bus_b2.pop1, bus_b1.pop0, bus_b1.pop1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pop_gate: got %b want 0000",
               {bus_b2.pop0, bus_b2.pop1, bus_b1.pop0, bus_b1.pop1});
    end
    drive_inputs();
    @(negedge clk);
    reset_L = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({obs_pop0[d], obs_pop1[d], obs_push[d], obs_data[d]} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle dut%0d: got pop=%b%b push=%b data=%h want all 0",
                 d, obs_pop1[d], obs_pop0[d], obs_push[d], obs_data[d]);
      end
    end
    load('{4'h5, 4'h6}, '{});
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (obs_push[d] !== 1'b1 || obs_data[d] !== 4'h6) begin
        n_fail++;
        $display("FAIL reset_pre dut%0d: got push=%b data=%h want push=1 data=6",
                 d, obs_push[d], obs_data[d]);
      end
    end
    #1 reset_L = 1'b0;
    #1;
    n_tests++;
    if ({bus_b2.push_out, bus_b1.push_out, bus_b2.data_out, bus_b1.data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got push=%b%b data=%h/%h want 0",
               bus_b2.push_out, bus_b1.push_out, bus_b2.data_out, bus_b1.data_out);
    end
  endtask

  task automatic test_only_q0();
    do_reset();
    load('{4'h1, 4'h2, 4'h3}, '{});
    for (int i = 0; i < 5; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if ({obs_pop1[d], obs_pop0[d], obs_push[d], obs_data[d]} !==
            {exp_pop1[d], exp_pop0[d], exp_push[d], exp_data[d]}) begin
          n_fail++;
          $display("FAIL only_q0 dut%0d cyc%0d: got pop=%b%b push=%b data=%h want %b%b %b %h",
                   d, i, obs_pop1[d], obs_pop0[d], obs_push[d], obs_data[d],
                   exp_pop1[d], exp_pop0[d], exp_push[d], exp_data[d]);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (got[d].size() != 3 || got[d][0] !== 4'h1 || got[d][1] !== 4'h2 ||
          got[d][2] !== 4'h3) begin
        n_fail++;
        $display("FAIL only_q0_order dut%0d: got %0d words %p want 1,2,3", d, got[d].size(),
                 got[d]);
      end
    end
  endtask

  // Shared by the interleave and stall scenarios; af_from > af_to disables the stall.
  task automatic run_interleave(input string name, input int af_from, input int af_to);
    logic [DW-1:0] ord [2][8];
    int trail [2];
    ord = '{'{4'h1, 4'h2, 4'h9, 4'hA, 4'h3, 4'h4, 4'hB, 4'hC},
            '{4'h1, 4'h9, 4'h2, 4'hA, 4'h3, 4'hB, 4'h4, 4'hC}};
    trail = '{0, 0};
    do_reset();
    load('{4'h1, 4'h2, 4'h3, 4'h4}, '{4'h9, 4'hA, 4'hB, 4'hC});
    for (int i = 0; i < 14; i++) begin
      af = (i >= af_from && i <= af_to);
      step();
      for (int d = 0; d < 2; d++) begin
        if (i >= af_from - 1 && i < af_to) trail[d] += int'(obs_push[d]);
        n_tests++;
        if ({obs_pop1[d], obs_pop0[d], obs_push[d], obs_data[d]} !==
            {exp_pop1[d], exp_pop0[d], exp_push[d], exp_data[d]}) begin
          n_fail++;
          $display("FAIL %s dut%0d cyc%0d: got pop=%b%b push=%b data=%h want %b%b %b %h",
                   name, d, i, obs_pop1[d], obs_pop0[d], obs_push[d], obs_data[d],
                   exp_pop1[d], exp_pop0[d], exp_push[d], exp_data[d]);
        end
      end
    end
    af = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (got[d].size() != 8) begin
        n_fail++;
        $display("FAIL %s_count dut%0d: got %0d words want 8", name, d, got[d].size());
      end
      for (int k = 0; k < 8; k++) begin
        n_tests++;
        if (k >= got[d].size() || got[d][k] !== ord[d][k]) begin
          n_fail++;
          $display("FAIL %s_order dut%0d idx%0d: got %p want %h", name, d, k, got[d],
                   ord[d][k]);
        end
      end
      if (af_from <= af_to) begin
        n_tests++;
        if (trail[d] != 1) begin
          n_fail++;
          $display("FAIL %s_trailing dut%0d: got %0d pushes in stall want 1", name, d,
                   trail[d]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_interleave("b2b", 99, 0);
  endtask

  task automatic test_stall();
    run_interleave("stall", 3, 5);
  endtask

  task automatic test_q1_short();
    logic [DW-1:0] ord [2][5];
    ord = '{'{4'h1, 4'h2, 4'h9, 4'h3, 4'h4}, '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4}};
    do_reset();
    load('{4'h1, 4'h2, 4'h3, 4'h4}, '{4'h9});
    for (int i = 0; i < 8; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if ((obs_pop1[d] && obs_e1[d]) ||
            {obs_pop1[d], obs_pop0[d], obs_push[d], obs_data[d]} !==
            {exp_pop1[d], exp_pop0[d], exp_push[d], exp_data[d]}) begin
          n_fail++;
          $display("FAIL q1_short dut%0d cyc%0d: got pop=%b%b push=%b data=%h e1=%b want %b%b %b %h",
                   d, i, obs_pop1[d], obs_pop0[d], obs_push[d], obs_data[d], obs_e1[d],
                   exp_pop1[d], exp_pop0[d], exp_push[d], exp_data[d]);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (got[d].size() != 5 || got[d][k] !== ord[d][k]) begin
          n_fail++;
          $display("FAIL q1_short_order dut%0d idx%0d: got %p want %h", d, k, got[d],
                   ord[d][k]);
        end
      end
    end
  endtask

  task automatic test_random();
    int total;
    logic [DW-1:0] w;
    total = 0;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      if (i < 230) begin
        if ($urandom_range(2) == 0 && q0[0].size() < 6) begin
          w = DW'($urandom);
          q0[0].push_back(w);
          q0[1].push_back(w);
          total++;
        end
        if ($urandom_range(2) == 0 && q1[0].size() < 6) begin
          w = DW'($urandom);
          q1[0].push_back(w);
          q1[1].push_back(w);
          total++;
        end
        af = ($urandom_range(3) == 0);
      end else begin
        af = 1'b0;
      end
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if ({obs_pop1[d], obs_pop0[d], obs_push[d], obs_data[d]} !==
            {exp_pop1[d], exp_pop0[d], exp_push[d], exp_data[d]}) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: got pop=%b%b push=%b data=%h want %b%b %b %h",
                   d, i, obs_pop1[d], obs_pop0[d], obs_push[d], obs_data[d],
                   exp_pop1[d], exp_pop0[d], exp_push[d], exp_data[d]);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (got[d].size() != total) begin
        n_fail++;
        $display("FAIL random_drain dut%0d: got %0d words want %0d", d, got[d].size(), total);
      end
    end
  endtask

  initial begin
    test_reset();
    test_only_q0();
    test_back_to_back();
    test_stall();
    test_q1_short();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Merge side of the demux split: two upstream show-ahead FIFOs (queue 0, queue 1) feed one downstream FIFO.
- Pops at most one word per cycle from a non-empty queue, using round-robin with a bounded burst.
- Registers the popped word and pushes it downstream.
- Stalls while the downstream FIFO reports almost-full.

Parameters:
- DATA_SIZE, 4, word width in bits; words pass through unmodified, selector bit included.
- BURST, 2, maximum consecutive words served from one queue while the other queue is non-empty; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- empty0  input  1  queue 0 empty flag.
- empty1  input  1  queue 1 empty flag.
- data_in0  input  DATA_SIZE  queue 0 head word; show-ahead, valid whenever empty0=0.
- data_in1  input  DATA_SIZE  queue 1 head word; show-ahead, valid whenever empty1=0.
- almost_full_out  input  1  downstream FIFO almost-full; 1 blocks all pops.
- pop0  output  1  combinational pop strobe to queue 0.
- pop1  output  1  combinational pop strobe to queue 1.
- push_out  output  1  registered push strobe to downstream FIFO.
- data_out  output  DATA_SIZE  registered word accompanying push_out.

Behaviour:
- Reset, asynchronous, reset_L=0:
  - push_out=0, data_out=0, state=IDLE, burst_cnt=0, last=1 (queue 0 wins first).
  - pop0 and pop1 are forced to 0 while reset_L=0.
- States: IDLE, SERVE0, SERVE1. The state register records which queue was popped in the previous cycle.
- Grant, combinational, evaluated each cycle:
  - Stall: no grant when almost_full_out=1 or both queues are empty. State stays unchanged; burst_cnt is held.
  - Only one queue non-empty: grant that queue, regardless of burst_cnt.
  - Both non-empty, state=SERVE0 and burst_cnt<BURST: grant queue 0.
  - Both non-empty, state=SERVE0 and burst_cnt=BURST: grant queue 1.
  - State=SERVE1 mirrors the SERVE0 rules.
  - Both non-empty, state=IDLE: grant the queue opposite to last.
- pop0 = grant0 and pop1 = grant1. They are mutually exclusive, never both 1.
- Next-state rules:
  - Grant to the same queue as the current SERVE state: burst_cnt increments, saturating at BURST.
  - Grant to the other queue, or from IDLE: state becomes the new SERVEx, burst_cnt=1, last=x.
  - No grant and both queues empty: state goes to IDLE, burst_cnt=0, last is kept.
  - No grant due to stall with data pending: state, burst_cnt and last are held.
- Output latency is one cycle. At the edge closing a cycle with popx=1, data_out<=data_inx and push_out<=1.
- In cycles without a pop, push_out<=0 and data_out holds its previous value.
- Boundary conditions:
  - almost_full_out rising in the same cycle as a candidate pop: the pop is suppressed that cycle. The word popped in the previous cycle is still pushed, because downstream absorbs it via the almost-full margin.
  - emptyx rising the cycle after a pop: that queue is not granted; no stale read occurs.
  - BURST=1: strict alternation while both queues are non-empty.
  - Reset asserted mid-transfer: the in-flight registered push is dropped; push_out falls immediately (asynchronous).
- Throughput: one word per cycle sustained while unstalled.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, SERVE0=2'd1, SERVE1=2'd2;
  - DATA_SIZE default;
  - a burst-counter width constant of 4 bits.
- One natural sub-module, rr_grant: combinational grant logic. Inputs: state, burst_cnt, empties, almost_full. Outputs: grant0, grant1.
- Top level holds the state register, counters and output register.

Test Plan:
- Reset release with both queues empty:
  - Expected: pop0=pop1=0, push_out=0, data_out=0.
  - Assert reset_L=0 mid-stream and check push_out drops without waiting for clk.
- Only queue 0 non-empty, holding words 4'h1,4'h2,4'h3, BURST=2:
  - Expected: pop0 asserted 3 consecutive cycles.
  - push_out=1 for 3 cycles, each one cycle later, with data_out 1,2,3 in order; pop1 never asserted.
- Both queues non-empty (q0: 1,2,3,4; q1: 9,A,B,C), BURST=2:
  - Expected push order: 1,2,9,A,3,4,B,C.
  - No idle cycles between words.
- Same stimulus with BURST=1:
  - Expected order: 1,9,2,A,3,B,4,C.
- almost_full_out=1 for 3 cycles in the middle of the BURST=2 case:
  - Expected: no pops during the stall.
  - Exactly one trailing push occurs in the first stall cycle.
  - After release, the sequence resumes exactly where it stopped, with the burst count preserved.
- Queue 1 goes empty after word 9 while queue 0 is still full:
  - Expected: arbiter returns to queue 0 immediately, without waiting out the burst.
  - No pop1 is issued while empty1=1.
